ram_access_arbiter: RTL and testbench

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

---
 rtl/ram_access_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-port 8x256 RAM.
//            It also has a clear engine that writes CLR_VAL to every address.
//            Grants are combinational. All RAM-side outputs are registered.
//            Read returns are steered back to the requesting port by a tag
//            pipeline that is RD_LAT+1 stages deep.
// Ports    : clk, rst                        - clock, async active-high reset
//            a_req/a_we/a_addr/a_wdata       - port A request side
//            a_gnt/a_rvalid/a_rdata          - port A accept / read return
//            b_*                             - port B, identical to port A
//            clr_req/clr_busy/clr_done       - sweep request / busy / done pulse
//            ram_addr/ram_data/ram_wren/
//            ram_rden/ram_q                  - single-port RAM connection
// Params   : RD_LAT  - cycles from registered ram_rden to valid ram_q (1 or 2)
//            CLR_VAL - value written to every address by a sweep
// Revision : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
    parameter int unsigned RD_LAT  = 2,
    parameter logic [7:0]  CLR_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,

    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,

    input  logic       clr_req,
    output logic       clr_busy,
    output logic       clr_done,

    output logic [7:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       ram_wren,
    output logic       ram_rden,
    input  logic [7:0] ram_q
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CLEAR = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]      r_state;
    logic [7:0]      r_clr_cnt;
    logic            r_last_b;      // 1: port B was granted most recently
    logic [RD_LAT:0] r_tag_a;
    logic [RD_LAT:0] r_tag_b;
    logic [7:0]      r_a_hold;
    logic [7:0]      r_b_hold;
    logic [7:0]      r_ram_addr;
    logic [7:0]      r_ram_data;
    logic            r_ram_wren;
    logic            r_ram_rden;

    logic w_idle;
    logic w_clr_start;
    logic w_arb_en;
    logic w_a_win;
    logic w_a_gnt;
    logic w_b_gnt;
    logic w_a_rd;
    logic w_b_rd;
    logic w_sweep_more;

    // Gating with rst keeps the combinational grants low while reset is held.
    assign w_idle       = (r_state == c_IDLE) && !rst;
    assign w_clr_start  = w_idle && clr_req;
    assign w_arb_en     = w_idle && !clr_req;

    // On a tie, A wins only when B holds the most-recent grant.
    assign w_a_win      = a_req && (!b_req || r_last_b);
    assign w_a_gnt      = w_arb_en && w_a_win;
    assign w_b_gnt      = w_arb_en && b_req && !w_a_win;
    assign w_a_rd       = w_a_gnt && !a_we;
    assign w_b_rd       = w_b_gnt && !b_we;

    // While this is high, another sweep address still has to be issued.
    assign w_sweep_more = (r_state == c_CLEAR) && (r_clr_cnt != 8'hFF);

    // ------------------------------------------------------------------------
    // Control FSM and sweep counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_clr_cnt <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_clr_cnt <= 8'd0;
                    if (clr_req) begin
                        r_state <= c_CLEAR;
                    end
                end
                c_CLEAR: begin
                    if (r_clr_cnt == 8'hFF) begin
                        r_state   <= c_DONE;
                        r_clr_cnt <= 8'd0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    r_state   <= c_IDLE;
                    r_clr_cnt <= 8'd0;
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_clr_cnt <= 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pointer: it moves only when a transfer is actually granted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_b <= 1'b1;
        end else if (w_a_gnt) begin
            r_last_b <= 1'b0;
        end else if (w_b_gnt) begin
            r_last_b <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered RAM command. The sweep command for address 0 is loaded on the
    // cycle the clear is accepted. As a result, RAM address k appears during
    // the k-th CLEAR cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_addr <= 8'd0;
            r_ram_data <= 8'd0;
            r_ram_wren <= 1'b0;
            r_ram_rden <= 1'b0;
        end else if (w_clr_start) begin
            r_ram_addr <= 8'd0;
            r_ram_data <= CLR_VAL;
            r_ram_wren <= 1'b1;
            r_ram_rden <= 1'b0;
        end else if (w_sweep_more) begin
            r_ram_addr <= r_clr_cnt + 8'd1;
            r_ram_data <= CLR_VAL;
            r_ram_wren <= 1'b1;
            r_ram_rden <= 1'b0;
        end else if (w_a_gnt) begin
            r_ram_addr <= a_addr;
            r_ram_data <= a_wdata;
            r_ram_wren <= a_we;
            r_ram_rden <= !a_we;
        end else if (w_b_gnt) begin
            r_ram_addr <= b_addr;
            r_ram_data <= b_wdata;
            r_ram_wren <= b_we;
            r_ram_rden <= !b_we;
        end else begin
            r_ram_wren <= 1'b0;
            r_ram_rden <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Read-return tag pipeline. Stage k holds the owner of a read that was
    // granted k+1 cycles earlier. The last stage lines up with valid ram_q.
    // The pipeline keeps shifting during a sweep, so in-flight reads still
    // come back on time.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_a <= '0;
            r_tag_b <= '0;
        end else begin
            r_tag_a <= {r_tag_a[RD_LAT-1:0], w_a_rd};
            r_tag_b <= {r_tag_b[RD_LAT-1:0], w_b_rd};
        end
    end

    // Hold registers give rdata its last returned value when rvalid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_hold <= 8'd0;
            r_b_hold <= 8'd0;
        end else begin
            if (r_tag_a[RD_LAT]) begin
                r_a_hold <= ram_q;
            end
            if (r_tag_b[RD_LAT]) begin
                r_b_hold <= ram_q;
            end
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_tag_a[RD_LAT];
    assign b_rvalid = r_tag_b[RD_LAT];
    assign a_rdata  = r_tag_a[RD_LAT] ? ram_q : r_a_hold;
    assign b_rdata  = r_tag_b[RD_LAT] ? ram_q : r_b_hold;
    assign clr_busy = (r_state == c_CLEAR);
    assign clr_done = (r_state == c_DONE);
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign ram_wren = r_ram_wren;
    assign ram_rden = r_ram_rden;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_arbiter
// Purpose  : Self-checking bench for ram_access_arbiter.
//            Instance 0 is built with RD_LAT=2 and instance 1 with RD_LAT=1.
//            The two instances share all request inputs, and each has its own
//            RAM model. A transaction-level model predicts grants, the RAM
//            command stream, sweep status and read returns on every cycle.
//            Directed sequences pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we, clr_req;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;

    logic       a_gnt0, b_gnt0, a_rvalid0, b_rvalid0, clr_busy0, clr_done0, ram_wren0, ram_rden0;
    logic [7:0] a_rdata0, b_rdata0, ram_addr0, ram_data0, ram_q0;
    logic       a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, clr_busy1, clr_done1, ram_wren1, ram_rden1;
    logic [7:0] a_rdata1, b_rdata1, ram_addr1, ram_data1, ram_q1;

    always #5 clk = ~clk;

    ram_access_arbiter #(.RD_LAT(2), .CLR_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
        .clr_req(clr_req), .clr_busy(clr_busy0), .clr_done(clr_done0),
        .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_wren(ram_wren0),
        .ram_rden(ram_rden0), .ram_q(ram_q0)
    );

    ram_access_arbiter #(.RD_LAT(1), .CLR_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .clr_req(clr_req), .clr_busy(clr_busy1), .clr_done(clr_done1),
        .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_wren(ram_wren1),
        .ram_rden(ram_rden1), .ram_q(ram_q1)
    );

    // RAM models: the read is captured on the edge that ends the rden cycle.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] q0a, q0b, q1a;
    always @(posedge clk) begin
        if (ram_wren0) mem0[ram_addr0] <= ram_data0;
        if (ram_rden0) q0a <= mem0[ram_addr0];
        q0b <= q0a;
        if (ram_wren1) mem1[ram_addr1] <= ram_data1;
        if (ram_rden1) q1a <= mem1[ram_addr1];
    end
    assign ram_q0 = q0b;
    assign ram_q1 = q1a;

    // rv[dut][port], rd[dut][port]; port 0 = A, port 1 = B.
    logic [1:0][1:0]      rv;
    logic [1:0][1:0][7:0] rd;
    assign rv = {{b_rvalid1, a_rvalid1}, {b_rvalid0, a_rvalid0}};
    assign rd = {{b_rdata1, a_rdata1}, {b_rdata0, a_rdata0}};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------------
    logic [7:0] mem_m [256];
    bit         m_last_b;
    int         m_sweep;        // -1 idle, 0..255 address being cleared, 256 done
    bit         m_wren, m_rden;
    logic [7:0] m_addr, m_data;
    bit         pv [2][2][8];
    logic [7:0] pd [2][2][8];
    logic [7:0] hold [2][2];

    initial begin : model_check
        int  cyc;
        bit  idle, eg_a, eg_b, we;
        int  slot, pi;
        logic [7:0] addr, wd;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctl0", {a_gnt0, b_gnt0, a_rvalid0, b_rvalid0, clr_busy0, clr_done0, ram_wren0, ram_rden0}, 0);
                chk("rst_dat0", {a_rdata0, b_rdata0, ram_addr0, ram_data0}, 0);
                chk("rst_ctl1", {a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, clr_busy1, clr_done1, ram_wren1, ram_rden1}, 0);
                chk("rst_dat1", {a_rdata1, b_rdata1, ram_addr1, ram_data1}, 0);
                m_last_b = 1'b1;
                m_sweep  = -1;
                m_wren   = 1'b0;
                m_rden   = 1'b0;
                for (int d = 0; d < 2; d++)
                    for (int p = 0; p < 2; p++) begin
                        hold[d][p] = 8'h00;
                        for (int s = 0; s < 8; s++) pv[d][p][s] = 1'b0;
                    end
            end else begin
                // RAM command predicted for this cycle.
                chk("ram_wren0", ram_wren0, m_wren);
                chk("ram_rden0", ram_rden0, m_rden);
                chk("ram_wren1", ram_wren1, m_wren);
                chk("ram_rden1", ram_rden1, m_rden);
                if (m_wren || m_rden) begin
                    chk("ram_addr0", ram_addr0, m_addr);
                    chk("ram_addr1", ram_addr1, m_addr);
                end
                if (m_wren) begin
                    chk("ram_data0", ram_data0, m_data);
                    chk("ram_data1", ram_data1, m_data);
                    mem_m[m_addr] = m_data;
                end
                chk("clr_busy0", clr_busy0, (m_sweep >= 0 && m_sweep < 256));
                chk("clr_done0", clr_done0, (m_sweep == 256));
                chk("clr_busy1", clr_busy1, (m_sweep >= 0 && m_sweep < 256));
                chk("clr_done1", clr_done1, (m_sweep == 256));

                // Grant rules: a lone requester wins; a tie goes to the port
                // that was not granted most recently.
                idle = (m_sweep < 0);
                eg_a = 1'b0;
                eg_b = 1'b0;
                if (idle && !clr_req) begin
                    if (a_req && b_req) begin
                        if (m_last_b) eg_a = 1'b1; else eg_b = 1'b1;
                    end else if (a_req) eg_a = 1'b1;
                    else if (b_req) eg_b = 1'b1;
                end
                chk("a_gnt0", a_gnt0, eg_a);
                chk("b_gnt0", b_gnt0, eg_b);
                chk("a_gnt1", a_gnt1, eg_a);
                chk("b_gnt1", b_gnt1, eg_b);

                // Read returns scheduled for this cycle.
                slot = cyc % 8;
                for (int d = 0; d < 2; d++)
                    for (int p = 0; p < 2; p++) begin
                        chk($sformatf("rvalid_d%0d_p%0d", d, p), rv[d][p], pv[d][p][slot]);
                        if (pv[d][p][slot]) hold[d][p] = pd[d][p][slot];
                        chk($sformatf("rdata_d%0d_p%0d", d, p), rd[d][p], hold[d][p]);
                        pv[d][p][slot] = 1'b0;
                    end

                // Predict the next cycle.
                m_wren = 1'b0;
                m_rden = 1'b0;
                if (idle && clr_req) begin
                    m_sweep = 0;
                    m_wren = 1'b1; m_addr = 8'h00; m_data = 8'h00;
                end else if (m_sweep >= 0 && m_sweep < 255) begin
                    m_sweep++;
                    m_wren = 1'b1; m_addr = m_sweep[7:0]; m_data = 8'h00;
                end else if (m_sweep == 255) begin
                    m_sweep = 256;
                end else if (m_sweep == 256) begin
                    m_sweep = -1;
                end else if (eg_a || eg_b) begin
                    we   = eg_a ? a_we    : b_we;
                    addr = eg_a ? a_addr  : b_addr;
                    wd   = eg_a ? a_wdata : b_wdata;
                    pi   = eg_b ? 1 : 0;
                    m_wren = we; m_rden = !we; m_addr = addr; m_data = wd;
                    m_last_b = eg_b;
                    if (!we) begin
                        pv[0][pi][(cyc + 3) % 8] = 1'b1;
                        pd[0][pi][(cyc + 3) % 8] = mem_m[addr];
                        pv[1][pi][(cyc + 2) % 8] = 1'b1;
                        pd[1][pi][(cyc + 2) % 8] = mem_m[addr];
                    end
                end
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    // Holds a request until it is granted. Returns in the cycle after the grant.
    task automatic issue(input int port, input bit we, input logic [7:0] addr, input logic [7:0] wd);
        bit ok;
        ok = 1'b0;
        if (port == 0) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
        else           begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ((port == 0) ? a_gnt0 : b_gnt0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        a_req = 1'b0;
        b_req = 1'b0;
        chk("gnt_timeout", ok, 1'b1);
    endtask

    // Called in the cycle after a read grant. Measures the return latency of
    // both builds.
    task automatic wait_ret(input int port, input logic [7:0] exp);
        int l0, l1, oth;
        logic [7:0] d0, d1;
        l0 = 0; l1 = 0; oth = 0; d0 = 8'h00; d1 = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rv[0][port] && l0 == 0) begin l0 = i; d0 = rd[0][port]; end
            if (rv[1][port] && l1 == 0) begin l1 = i; d1 = rd[1][port]; end
            if (rv[0][1-port] || rv[1][1-port]) oth++;
        end
        tick();
        chk("ret_lat_rdlat2", l0, 3);
        chk("ret_lat_rdlat1", l1, 2);
        chk("ret_data_rdlat2", d0, exp);
        chk("ret_data_rdlat1", d1, exp);
        chk("ret_other_port_quiet", oth, 0);
    endtask

    task automatic read_check(input int port, input logic [7:0] addr, input logic [7:0] exp);
        issue(port, 1'b0, addr, 8'h00);
        wait_ret(port, exp);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (clr_done0) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        chk("clr_done_seen", seen, 1'b1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int ng, busy, done, ta, tb;
        bit found;
        logic [7:0] da, db;
        rst = 1'b1; clr_req = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single write, then a read of the same address.
        issue(0, 1'b1, 8'h10, 8'h5A);
        read_check(0, 8'h10, 8'h5A);

        // Contention from a fresh reset: grants go A, B, A, B.
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'hA0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h21; b_wdata = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_a_gnt", a_gnt0, (i % 2 == 0));
            chk("rr_b_gnt", b_gnt0, (i % 2 == 1));
        end
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // Interleaved reads from A and B on consecutive cycles.
        issue(0, 1'b1, 8'h01, 8'h11);
        issue(1, 1'b1, 8'h02, 8'h22);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        @(negedge clk);
        chk("il_a_gnt", a_gnt0, 1'b1);
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        @(negedge clk);
        chk("il_b_gnt", b_gnt0, 1'b1);
        tick();
        b_req = 1'b0;
        ta = 0; tb = 0; da = 8'h00; db = 8'h00;
        for (int i = 2; i < 10; i++) begin
            @(negedge clk);
            if (a_rvalid0 && ta == 0) begin ta = i; da = a_rdata0; end
            if (b_rvalid0 && tb == 0) begin tb = i; db = b_rdata0; end
        end
        tick();
        chk("il_a_lat", ta, 3);
        chk("il_b_lat", tb, 4);
        chk("il_a_data", da, 8'h11);
        chk("il_b_data", db, 8'h22);

        // Full clear sweep with port A waiting.
        issue(0, 1'b1, 8'hFF, 8'h77);
        read_check(1, 8'hFF, 8'h77);
        clr_req = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'hFF;
        ng = -1; busy = 0; done = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (clr_busy0) busy++;
            if (clr_done0) done++;
            if (a_gnt0) begin
                ng = k;
                break;
            end
            tick();
            clr_req = 1'b0;
        end
        tick();
        a_req = 1'b0;
        chk("clr_gnt_blocked_cycles", ng, 258);
        chk("clr_busy_cycles", busy, 256);
        chk("clr_done_pulses", done, 1);
        wait_ret(0, 8'h00);

        // A read in flight when a clear starts. The clear request is held
        // into the sweep, where it must be ignored.
        issue(0, 1'b1, 8'h10, 8'h3C);
        issue(0, 1'b0, 8'h10, 8'h00);
        clr_req = 1'b1;
        wait_ret(0, 8'h3C);
        clr_req = 1'b0;
        wait_done();

        // Reset in the middle of a sweep, then a fresh sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ram_wren0 && ram_addr0 == 8'd99) begin
                found = 1'b1;
                break;
            end
        end
        chk("sweep_reached_99", found, 1'b1);
        @(posedge clk);
        #2;
        chk("sweep_addr_100", ram_addr0, 8'd100);
        rst = 1'b1;
        #1;
        chk("midrst_ctl", {a_gnt0, b_gnt0, a_rvalid0, b_rvalid0, clr_busy0, clr_done0, ram_wren0, ram_rden0}, 0);
        chk("midrst_dat", {a_rdata0, b_rdata0, ram_addr0, ram_data0}, 0);
        tick();
        tick();
        rst = 1'b0;
        done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (clr_done0 || clr_done1 || clr_busy0) done++;
        end
        tick();
        chk("no_done_after_rst", done, 0);
        clr_req = 1'b1;
        @(negedge clk);
        tick();
        clr_req = 1'b0;
        @(negedge clk);
        chk("restart_wren", ram_wren0, 1'b1);
        chk("restart_addr0", ram_addr0, 8'h00);
        tick();
        wait_done();

        issue(1, 1'b1, 8'h80, 8'hC3);
        read_check(1, 8'h80, 8'hC3);
        read_check(0, 8'hFF, 8'h00);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
